wave_reader: RTL
================

Name: wave_reader

Overview:
- Read-side controller for the registered wavetable ROMs (one-cycle read latency, ADDR_WIDTH address, signed DATA_WIDTH sample).
- Runs a phase accumulator at the audio sample rate and drives the ROM address.
- Waits out the ROM latency, applies gate and volume scaling, then presents one sample per tick on a valid/ready interface to the downstream DAC/serializer stage.

Parameters:
DATA_WIDTH, 16, sample width (two's complement); matches ROM data width
ADDR_WIDTH, 8, ROM address width
PHASE_WIDTH, 24, phase accumulator width; ROM address = phase[PHASE_WIDTH-1 -: ADDR_WIDTH]
VOL_WIDTH, 4, unsigned volume width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe at the audio sample rate
freq_word  in  PHASE_WIDTH  phase increment per sample
gate  in  1  note on (1) / off (0)
volume  in  VOL_WIDTH  amplitude, 0 = silent, max = (2^VOL_WIDTH-1)/2^VOL_WIDTH
rom_addr  out  ADDR_WIDTH  registered ROM read address
rom_dout  in  DATA_WIDTH  ROM registered read data
sample_out  out  DATA_WIDTH  scaled signed sample
sample_valid  out  1  sample_out valid
sample_ready  in  1  downstream accepts sample
overrun  out  1  one-cycle pulse: tick dropped because busy

Behaviour:
- Reset is decided: one clock `clk`; reset `reset_n` is asynchronous, active-low.
- Reset values: state IDLE, phase 0, rom_addr 0, sample_out 0, sample_valid 0, overrun 0, latched controls 0.
- Reset mid-operation clears all state immediately. Any pending or held sample is discarded. The next accepted tick reads address 0.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE, sample_tick=1 (edge T):
  - Latch gate and volume.
  - rom_addr <= phase top bits, using the pre-increment phase.
  - If gate=1: phase <= phase + freq_word, mod 2^PHASE_WIDTH (wraps silently).
  - If gate=0: phase <= 0 and rom_addr <= 0.
  - Go to FETCH.
- FETCH (edge T+1): ROM captures the address. Go to WAIT.
- WAIT (edge T+2):
  - sample_out <= scaled rom_dout; sample_valid <= 1; go to HOLD.
  - Tick-to-valid latency is fixed at 2 edges after the accepting edge.
- HOLD:
  - sample_out and sample_valid stay stable until sample_valid && sample_ready.
  - On that handshake edge: sample_valid <= 0, go to IDLE.
  - A tick on the handshake edge itself is not accepted; it counts as dropped.
- Dropped tick: sample_tick=1 in any state other than IDLE.
  - Tick is ignored; phase does not advance.
  - overrun pulses high for exactly one cycle, on the edge after the tick.
- Scaling, computed at full precision of DATA_WIDTH+VOL_WIDTH+1 bits:
  - Latched gate=0 or volume=0: result is 0.
  - Otherwise: result = (signed rom_dout * unsigned volume) >>> VOL_WIDTH, an arithmetic shift that rounds toward -inf, truncated to DATA_WIDTH.
  - The result always fits; no saturation is needed.
- freq_word is sampled only on the accepting edge. Changes at other times have no effect on the in-flight sample.
- rom_addr holds its value outside accept edges.

Decomposition:
- Package wave_pkg:
  - typedef enum wave_state_t {IDLE, FETCH, WAIT, HOLD}.
  - Default width constants SAMPLE_W=16, WAVE_ADDR_W=8, PHASE_W=24, VOL_W=4, shared with the ROMs and the sequencer top.
- Sub-module wave_scaler: purely combinational gate/volume multiply-shift. Instantiated once, verified standalone.
- The ROM is instantiated outside this block and connected via rom_addr/rom_dout.

Test Plan:
Bench ROM model: one-cycle latency, ram[n] = {n[7:0], 8'h00}.
1. Reset, gate=1, volume=15, freq_word=0x010000, sample_ready=1, ticks every 20 cycles -> rom_addr 0x00, 0x01, 0x02; sample_out 0x0000, 0x00F0, 0x01E0; sample_valid rises exactly at edge T+2, high for one cycle.
2. freq_word=0x800000, volume=15, 4 ticks -> addresses 0x00, 0x80, 0x00, 0x80 (wrap); samples 0x0000, 0x8800 (-30720), 0x0000, 0x8800.
3. volume=1, force phase to address 0x80 -> sample_out 0xF800 (-32768>>>4 = -2048). volume=0 -> 0x0000.
4. gate=0 tick after phase reaches 0x05xxxx -> sample_out 0x0000, rom_addr 0. Next gate=1 tick reads address 0x00.
5. sample_ready=0 for 30 cycles, ticks every 10 cycles -> sample_out/valid stable; each dropped tick gives one overrun pulse; phase frozen. After ready=1, next tick reads the address following the held sample.
6. reset_n asserted asynchronously while in FETCH -> sample_valid, sample_out, rom_addr go 0 without a clock edge. After release, first tick reads address 0x00.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared wavetable types and default widths for the ROMs, reader and sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wave_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int WAVE_ADDR_W = 8;
  localparam int PHASE_W     = 24;
  localparam int VOL_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } wave_state_t;

endpackage

// File: rtl/wave_scaler.sv
// Gate/volume scaling of one signed wavetable sample: (din * volume) >>> VOL_WIDTH.
// Latency: combinational.
// Backpressure: none; the output follows the inputs.
module wave_scaler #(
  parameter int DATA_WIDTH = 16,
  parameter int VOL_WIDTH  = 4
) (
  input  logic                  gate,
  input  logic [VOL_WIDTH-1:0]  volume,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = DATA_WIDTH + VOL_WIDTH + 1;

  logic signed [PW-1:0] din_x;
  logic signed [PW-1:0] vol_x;
  logic signed [PW-1:0] prod;
  logic                 unused_bits;

  // Full-precision product: sample sign-extended, volume zero-extended.
  assign din_x = {{(VOL_WIDTH+1){din[DATA_WIDTH-1]}}, din};
  assign vol_x = {{(DATA_WIDTH+1){1'b0}}, volume};
  assign prod  = din_x * vol_x;

  // Dropping the low VOL_WIDTH bits is an arithmetic shift (floor); the top
  // bit is a pure sign copy because |volume| < 2^VOL_WIDTH.
  assign unused_bits = ^{prod[PW-1], prod[VOL_WIDTH-1:0]};

  // Silence on gate off or zero volume, otherwise the shifted product.
  always_comb begin
    dout = '0;
    if (gate && (volume != '0))
      dout = prod[DATA_WIDTH+VOL_WIDTH-1:VOL_WIDTH];
  end

endmodule

// File: rtl/wave_reader.sv
// Wavetable read controller: phase accumulator -> ROM address -> scaled sample.
// Latency: sample_valid rises 2 edges after the edge that accepts sample_tick.
// Backpressure: sample held until sample_ready; ticks while busy are dropped and flagged on overrun.
module wave_reader
  import wave_pkg::*;
#(
  parameter int DATA_WIDTH  = SAMPLE_W,
  parameter int ADDR_WIDTH  = WAVE_ADDR_W,
  parameter int PHASE_WIDTH = PHASE_W,
  parameter int VOL_WIDTH   = VOL_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sample_tick,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic                   gate,
  input  logic [VOL_WIDTH-1:0]   volume,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_dout,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun
);

  wave_state_t            state;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   gate_q;
  logic [VOL_WIDTH-1:0]   vol_q;
  logic [DATA_WIDTH-1:0]  scaled;

  // Scaling uses the controls latched with the tick, not the live inputs.
  wave_scaler #(
    .DATA_WIDTH (DATA_WIDTH),
    .VOL_WIDTH  (VOL_WIDTH)
  ) u_scaler (
    .gate   (gate_q),
    .volume (vol_q),
    .din    (rom_dout),
    .dout   (scaled)
  );

  // Sequencer: accept tick, wait out the ROM register, present and hold the sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase        <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      gate_q       <= 1'b0;
      vol_q        <= '0;
    end else begin
      // Any tick outside IDLE is lost; flag it for exactly one cycle.
      overrun <= sample_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_tick) begin
            gate_q <= gate;
            vol_q  <= volume;
            if (gate) begin
              rom_addr <= phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
              phase    <= phase + freq_word;
            end else begin
              // Note off restarts the waveform from its first entry.
              rom_addr <= '0;
              phase    <= '0;
            end
            state <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          sample_out   <= scaled;
          sample_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
